// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: grants the single frame-memory port to display reads or
// capture writes one burst at a time. Reads have priority; writes get a turn
// after STARVE_MAX consecutive reads. Burst addresses are generated here, and
// the display/capture buffers are swapped at frame boundaries.
module frame_mem_arbiter #(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 345600,
  parameter int ADDR_W      = 20,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_beat,
  output logic              rd_grant,
  output logic              wr_grant,
  output logic              disp_buf,
  output logic              rd_done,
  output logic              wr_full
);

  localparam int OFF_W  = ADDR_W - 1;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int STV_W  = $clog2(STARVE_MAX + 1);

  localparam logic [OFF_W-1:0]  BURST_OFF  = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  FRAME_OFF  = OFF_W'(FRAME_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STV_W-1:0]  STARVE_TOP = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, CMD, BURST} state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    rd_addr_q, rd_addr_d;
  logic [OFF_W-1:0]    wr_addr_q, wr_addr_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                pend_q, pend_d;
  logic                is_wr_q, is_wr_d;
  logic                disp_q, disp_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_full_q, wr_full_d;
  logic                valid_q, valid_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_grant_q, rd_grant_d;
  logic                wr_grant_q, wr_grant_d;

  logic                wr_ok;
  logic [OFF_W-1:0]    rd_next, wr_next;

  // A write is only eligible while the capture buffer still has room.
  assign wr_ok   = wr_req & ~wr_full_q;
  assign rd_next = rd_addr_q + BURST_OFF;
  assign wr_next = wr_addr_q + BURST_OFF;

  // Next-state, arbitration, address generation and frame bookkeeping.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    starve_d   = starve_q;
    beat_d     = beat_q;
    pend_d     = pend_q | frame_start;
    is_wr_d    = is_wr_q;
    disp_d     = disp_q;
    rd_done_d  = rd_done_q;
    wr_full_d  = wr_full_q;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    rd_grant_d = rd_grant_q;
    wr_grant_d = wr_grant_q;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          // Frame origin: restart the display fetch; swap buffers only when
          // the capture side has a complete frame ready.
          rd_addr_d = '0;
          rd_done_d = 1'b0;
          if (wr_full_q) begin
            disp_d    = ~disp_q;
            wr_addr_d = '0;
            wr_full_d = 1'b0;
          end
          pend_d = frame_start;
        end else if (rd_req & ~rd_done_q & ~(wr_ok & (starve_q == STARVE_TOP))) begin
          state_d    = CMD;
          is_wr_d    = 1'b0;
          valid_d    = 1'b1;
          write_d    = 1'b0;
          addr_d     = {disp_q, rd_addr_q};
          rd_grant_d = 1'b1;
          beat_d     = '0;
          if (wr_ok) starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
          else       starve_d = '0;
        end else if (wr_ok) begin
          state_d    = CMD;
          is_wr_d    = 1'b1;
          valid_d    = 1'b1;
          write_d    = 1'b1;
          addr_d     = {~disp_q, wr_addr_q};
          wr_grant_d = 1'b1;
          beat_d     = '0;
          starve_d   = '0;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          state_d = BURST;
          valid_d = 1'b0;
        end
      end
      BURST: begin
        if (mem_beat) begin
          if (beat_q == BEAT_LAST) begin
            state_d    = IDLE;
            beat_d     = '0;
            rd_grant_d = 1'b0;
            wr_grant_d = 1'b0;
            if (is_wr_q) begin
              wr_addr_d = wr_next;
              if (wr_next == FRAME_OFF) wr_full_d = 1'b1;
            end else begin
              rd_addr_d = rd_next;
              if (rd_next == FRAME_OFF) rd_done_d = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns everything to idle with buffer 0 displayed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      starve_q   <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      disp_q     <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_full_q  <= 1'b0;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      rd_grant_q <= 1'b0;
      wr_grant_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      starve_q   <= starve_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      is_wr_q    <= is_wr_d;
      disp_q     <= disp_d;
      rd_done_q  <= rd_done_d;
      wr_full_q  <= wr_full_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
    end
  end

  assign mem_cmd_valid = valid_q;
  assign mem_cmd_write = write_q;
  assign mem_cmd_addr  = addr_q;
  assign rd_grant      = rd_grant_q;
  assign wr_grant      = wr_grant_q;
  assign disp_buf      = disp_q;
  assign rd_done       = rd_done_q;
  assign wr_full       = wr_full_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Testbench for frame_mem_arbiter: a transaction-level reference model predicts
// each memory command and the per-cycle grant/frame status; a monitor compares.
module tb_frame_mem_arbiter;

  localparam int BL   = 8;
  localparam int FW   = 64;
  localparam int AW   = 20;
  localparam int SM   = 4;
  localparam int HALF = 1 << (AW - 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic mem_cmd_ready = 1'b0, mem_beat = 1'b0;
  logic mem_cmd_valid, mem_cmd_write, rd_grant, wr_grant, disp_buf, rd_done, wr_full;
  logic [AW-1:0] mem_cmd_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit wr;
    int addr;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t log_q[$];

  typedef enum {M_IDLE, M_CMD, M_BURST} mphase_t;

  // Reference model state: a port-ownership phase plus frame progress in words.
  mphase_t m_phase;
  bit      m_wr, m_pend, m_disp, m_rd_done, m_wr_full;
  int      m_rd_off, m_wr_off, m_starve, m_beats;

  int p_rd, p_wr, p_rdy, p_beat, p_fs;
  bit fs_force = 1'b0;
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  cmd_t cur;

  frame_mem_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .rd_req(rd_req), .wr_req(wr_req),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_beat(mem_beat), .rd_grant(rd_grant), .wr_grant(wr_grant),
    .disp_buf(disp_buf), .rd_done(rd_done), .wr_full(wr_full)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_wr = 0; m_pend = 0; m_disp = 0;
    m_rd_done = 0; m_wr_full = 0; m_rd_off = 0; m_wr_off = 0;
    m_starve = 0; m_beats = 0;
    exp_q.delete();
  endtask

  task automatic issue(input bit wr, input int addr);
    cmd_t c;
    c.wr = wr; c.addr = addr;
    exp_q.push_back(c);
    m_wr = wr;
    m_phase = M_CMD;
  endtask

  // One clock of the arbitration rules, using the inputs held over that edge.
  task automatic model_step();
    bit wr_ok;
    bit fs;
    if (reset) begin
      model_reset();
      return;
    end
    fs = frame_start;
    wr_ok = wr_req && !m_wr_full;
    case (m_phase)
      M_IDLE: begin
        if (m_pend) begin
          m_pend = 0; m_rd_off = 0; m_rd_done = 0;
          if (m_wr_full) begin
            m_disp = !m_disp; m_wr_off = 0; m_wr_full = 0;
          end
        end else if (rd_req && !m_rd_done && !(wr_ok && m_starve == SM)) begin
          m_starve = wr_ok ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
          issue(0, (m_disp ? HALF : 0) + m_rd_off);
        end else if (wr_ok) begin
          m_starve = 0;
          issue(1, (m_disp ? 0 : HALF) + m_wr_off);
        end
      end
      M_CMD: if (mem_cmd_ready) begin
        m_phase = M_BURST; m_beats = 0;
      end
      M_BURST: if (mem_beat) begin
        m_beats++;
        if (m_beats == BL) begin
          m_phase = M_IDLE;
          if (m_wr) begin
            m_wr_off += BL; m_wr_full = (m_wr_off == FW);
          end else begin
            m_rd_off += BL; m_rd_done = (m_rd_off == FW);
          end
        end
      end
      default: m_phase = M_IDLE;
    endcase
    if (fs) m_pend = 1;
  endtask

  task automatic drive_inputs();
    rd_req        = ($urandom_range(99) < p_rd);
    wr_req        = ($urandom_range(99) < p_wr);
    mem_cmd_ready = ($urandom_range(99) < p_rdy);
    mem_beat      = ($urandom_range(99) < p_beat);
    frame_start   = fs_force || ($urandom_range(999) < p_fs);
    fs_force      = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase(input mphase_t ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      cycle();
      n++;
    end
    check("wait_bound", n < budget, 1);
  endtask

  task automatic set_mode(input int rd, input int wr, input int rdy, input int beat, input int fs);
    p_rd = rd; p_wr = wr; p_rdy = rdy; p_beat = beat; p_fs = fs;
  endtask

  // Monitor: per-cycle status against the model, command contents from the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_grant", rd_grant, m_phase != M_IDLE && !m_wr);
      check("wr_grant", wr_grant, m_phase != M_IDLE && m_wr);
      check("cmd_valid", mem_cmd_valid, m_phase == M_CMD);
      check("disp_buf", disp_buf, m_disp);
      check("rd_done", rd_done, m_rd_done);
      check("wr_full", wr_full, m_wr_full);
      if (mem_cmd_valid && !prev_valid) begin
        check("cmd_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          log_q.push_back(cur);
        end
      end
      if (mem_cmd_valid) begin
        check("cmd_write", mem_cmd_write, cur.wr);
        check("cmd_addr", mem_cmd_addr, cur.addr);
      end
      prev_valid = mem_cmd_valid;
    end
  end

  initial begin
    bit pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    model_reset();
    set_mode(0, 0, 100, 100, 0);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", mem_cmd_valid, 0);
    check("rst_rd_grant", rd_grant, 0);
    check("rst_wr_grant", wr_grant, 0);
    check("rst_disp", disp_buf, 0);
    check("rst_addr", mem_cmd_addr, 0);
    mon_en = 1'b1;
    run(2);
    reset = 1'b0;

    // Reads only: a full frame of read bursts, then silence until frame_start.
    set_mode(100, 0, 100, 100, 0);
    for (int n = 0; n < 200 && !m_rd_done; n++) cycle();
    check("rd_done_reached", rd_done, 1);
    check("rd_burst_count", log_q.size(), FW / BL);
    for (int i = 0; i < log_q.size(); i++) check("rd_seq_addr", log_q[i].addr, i * BL);
    run(20);
    check("rd_quiet_after_done", rd_grant, 0);
    log_q.delete();
    set_mode(0, 0, 100, 100, 0);
    fs_force = 1;
    cycle();
    set_mode(100, 0, 100, 100, 0);
    run(15);
    check("rd_restart_count", log_q.size() > 0, 1);
    if (log_q.size() > 0) check("rd_restart_addr", log_q[0].addr, 0);

    // Both requesting: four reads then one write, writes into buffer 1.
    set_mode(0, 0, 100, 100, 0);
    run(15);
    fs_force = 1;
    cycle();
    log_q.delete();
    set_mode(100, 100, 100, 100, 0);
    run(130);
    check("pattern_count", log_q.size() >= 10, 1);
    if (log_q.size() >= 10) begin
      for (int i = 0; i < 10; i++) check("pattern_wr", log_q[i].wr, pat[i]);
      check("first_wr_addr", log_q[4].addr, HALF);
    end
    run(200);
    check("wr_full_reached", wr_full, 1);
    run(20);
    check("wr_ignored_when_full", wr_grant, 0);

    // Frame boundary with a full capture buffer swaps buffers.
    set_mode(0, 0, 100, 100, 0);
    run(2);
    fs_force = 1;
    cycle();
    run(3);
    check("swap_disp", disp_buf, 1);
    log_q.delete();
    set_mode(0, 100, 100, 100, 0);
    run(20);
    check("swap_wr_count", log_q.size() > 0, 1);
    if (log_q.size() > 0) check("swap_wr_addr", log_q[0].addr, 0);

    // Controller stalls the command for several cycles.
    set_mode(100, 0, 0, 100, 0);
    wait_phase(M_CMD, 40);
    run(5);
    check("stall_valid_held", mem_cmd_valid, 1);
    check("stall_grant_held", rd_grant, 1);
    set_mode(100, 0, 100, 100, 0);
    run(3);

    // frame_start during a burst: burst completes, restart applies afterwards.
    set_mode(100, 50, 100, 70, 0);
    wait_phase(M_BURST, 40);
    fs_force = 1;
    run(40);

    // Randomised traffic.
    set_mode(60, 60, 70, 60, 10);
    run(4000);

    // Asynchronous reset mid-burst.
    set_mode(100, 0, 100, 50, 0);
    wait_phase(M_BURST, 60);
    #3 reset = 1'b1;
    #1;
    check("async_rst_rd_grant", rd_grant, 0);
    check("async_rst_wr_grant", wr_grant, 0);
    check("async_rst_valid", mem_cmd_valid, 0);
    check("async_rst_disp", disp_buf, 0);
    check("async_rst_rd_done", rd_done, 0);
    check("async_rst_wr_full", wr_full, 0);
    model_reset();
    cycle();
    reset = 1'b0;
    log_q.delete();
    set_mode(100, 0, 100, 100, 0);
    run(15);
    check("post_rst_count", log_q.size() > 0, 1);
    if (log_q.size() > 0) check("post_rst_addr", log_q[0].addr, 0);
    check("post_rst_disp", disp_buf, 0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
